// File: rtl/barrido_tabla_verdad.sv
// Truth-table sweeper: walks every input combination through a small boolean
// function, captures its 1-bit response per vector and compares against a reference table.
module barrido_tabla_verdad #(
    parameter int ANCHO_ENTRADA = 4,
    parameter int CICLOS_ESPERA = 1
) (
    input  logic                            Reloj,
    input  logic                            Reset,
    input  logic                            Inicio,
    input  logic                            Respuesta,
    input  logic [(1<<ANCHO_ENTRADA)-1:0]   Esperada,
    output logic [ANCHO_ENTRADA-1:0]        Estimulo,
    output logic [(1<<ANCHO_ENTRADA)-1:0]   TablaVerdad,
    output logic                            Ocupado,
    output logic                            Listo,
    output logic                            Coincide
);

    localparam int TAM = 1 << ANCHO_ENTRADA;
    localparam int CW  = $clog2(CICLOS_ESPERA + 1);
    localparam logic [CW-1:0]            ULTIMO_CICLO  = CW'(CICLOS_ESPERA - 1);
    localparam logic [ANCHO_ENTRADA-1:0] ULTIMO_VECTOR = '1;

    typedef enum logic {REPOSO, BARRIDO} estado_t;

    estado_t                  estado_q, estado_d;
    logic [ANCHO_ENTRADA-1:0] estimulo_q, estimulo_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [TAM-1:0]           tabla_q, tabla_d;
    logic                     ocupado_q, ocupado_d;
    logic                     listo_q, listo_d;
    logic                     coincide_q, coincide_d;

    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            estado_q   <= REPOSO;
            estimulo_q <= '0;
            cnt_q      <= '0;
            tabla_q    <= '0;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
            coincide_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            estimulo_q <= estimulo_d;
            cnt_q      <= cnt_d;
            tabla_q    <= tabla_d;
            ocupado_q  <= ocupado_d;
            listo_q    <= listo_d;
            coincide_q <= coincide_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        estimulo_d = estimulo_q;
        cnt_d      = cnt_q;
        tabla_d    = tabla_q;
        ocupado_d  = ocupado_q;
        listo_d    = 1'b0;
        coincide_d = coincide_q;
        case (estado_q)
            REPOSO: begin
                estimulo_d = '0;
                if (Inicio) begin
                    estado_d   = BARRIDO;
                    cnt_d      = '0;
                    tabla_d    = '0;
                    coincide_d = 1'b0;
                    ocupado_d  = 1'b1;
                end
            end
            BARRIDO: begin
                cnt_d = cnt_q + CW'(1);
                // Sample while the vector is still applied, on its last hold cycle.
                if (cnt_q == ULTIMO_CICLO) begin
                    tabla_d[estimulo_q] = Respuesta;
                    cnt_d               = '0;
                    if (estimulo_q != ULTIMO_VECTOR) begin
                        estimulo_d = estimulo_q + ANCHO_ENTRADA'(1);
                    end else begin
                        estado_d   = REPOSO;
                        estimulo_d = '0;
                        ocupado_d  = 1'b0;
                        listo_d    = 1'b1;
                        coincide_d = (tabla_d == Esperada);
                    end
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    assign Estimulo    = estimulo_q;
    assign TablaVerdad = tabla_q;
    assign Ocupado     = ocupado_q;
    assign Listo       = listo_q;
    assign Coincide    = coincide_q;

endmodule
